// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory-stage load/store unit with req/ack data port; optional LSU_MISALIGN_TRAP_EN
module mem_stage_lsu #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  logic [2:0]  ldst_ctrl,
   input  logic        mem_write,
   input  logic        mem_to_reg,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        dmem_req,
   output logic [3:0]  dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        bus_err,
   output logic        misalign
);
   typedef enum logic {IDLE, ACCESS} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             load_q;
   logic [2:0]       ctrl_q;
   logic [1:0]       lo_q;

   logic is_store, is_load, is_half, is_word, bad, start, timeout;
   logic [1:0]  lo;
   logic [3:0]  we_next;
   logic [31:0] wdata_next, fmt;
   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   assign is_store = valid & mem_write & (ldst_ctrl >= 3'd5);
   assign is_load  = valid & mem_to_reg & ~mem_write & (ldst_ctrl <= 3'd4);
   assign is_half  = (ldst_ctrl == 3'd1) | (ldst_ctrl == 3'd4) | (ldst_ctrl == 3'd6);
   assign is_word  = (ldst_ctrl == 3'd2) | (ldst_ctrl == 3'd7);

`ifdef LSU_MISALIGN_TRAP_EN
   assign bad = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
   assign lo  = addr[1:0];
`else
   // Offending low bits are dropped so the access proceeds aligned.
   assign bad = 1'b0;
   assign lo  = is_word ? 2'b00 : (is_half ? {addr[1], 1'b0} : addr[1:0]);
`endif

   // misalign high means the held instruction was already consumed by the trap.
   assign start   = (state == IDLE) & (is_load | is_store) & ~misalign;
   assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      stall = 1'b0;
      if (state == IDLE) stall = start;
      else               stall = ~dmem_ack & ~timeout;
   end

   always_comb begin
      we_next    = 4'b0000;
      wdata_next = store_data;
      case (ldst_ctrl)
         3'd5: begin
            we_next    = 4'b1000 >> lo;
            wdata_next = {4{store_data[7:0]}};
         end
         3'd6: begin
            we_next    = lo[1] ? 4'b0011 : 4'b1100;
            wdata_next = {2{store_data[15:0]}};
         end
         3'd7:    we_next = 4'b1111;
         default: we_next = 4'b0000;
      endcase
   end

   always_comb begin
      case (lo_q)
         2'd0:    rbyte = dmem_rdata[31:24];
         2'd1:    rbyte = dmem_rdata[23:16];
         2'd2:    rbyte = dmem_rdata[15:8];
         default: rbyte = dmem_rdata[7:0];
      endcase
      rhalf = lo_q[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
      case (ctrl_q)
         3'd0:    fmt = {{24{rbyte[7]}}, rbyte};
         3'd1:    fmt = {{16{rhalf[15]}}, rhalf};
         3'd3:    fmt = {24'd0, rbyte};
         3'd4:    fmt = {16'd0, rhalf};
         default: fmt = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         load_q     <= 1'b0;
         ctrl_q     <= 3'd0;
         lo_q       <= 2'd0;
         dmem_req   <= 1'b0;
         dmem_we    <= 4'd0;
         dmem_addr  <= 32'd0;
         dmem_wdata <= 32'd0;
         load_data  <= 32'd0;
         load_valid <= 1'b0;
         bus_err    <= 1'b0;
         misalign   <= 1'b0;
      end else begin
         load_valid <= 1'b0;
         bus_err    <= 1'b0;
         misalign   <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (bad) begin
                     misalign <= 1'b1;
                  end else begin
                     state      <= ACCESS;
                     cnt        <= '0;
                     dmem_req   <= 1'b1;
                     dmem_we    <= we_next;
                     dmem_addr  <= {addr[31:2], 2'b00};
                     dmem_wdata <= wdata_next;
                     load_q     <= is_load;
                     ctrl_q     <= ldst_ctrl;
                     lo_q       <= lo;
                  end
               end
            end
            ACCESS: begin
               if (dmem_ack) begin
                  state    <= IDLE;
                  dmem_req <= 1'b0;
                  dmem_we  <= 4'd0;
                  if (load_q) begin
                     load_data  <= fmt;
                     load_valid <= 1'b1;
                  end
               end else if (timeout) begin
                  state    <= IDLE;
                  dmem_req <= 1'b0;
                  dmem_we  <= 4'd0;
                  bus_err  <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu (TIMEOUT_CYCLES=4)
module tb_mem_stage_lsu;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [2:0]  ldst_ctrl = 3'd0;
   logic        mem_write = 1'b0;
   logic        mem_to_reg = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] store_data = 32'd0;
   logic        dmem_req;
   logic [3:0]  dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = 32'd0;
   logic        stall;
   logic [31:0] load_data;
   logic        load_valid;
   logic        bus_err;
   logic        misalign;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb[$];

   mem_stage_lsu #(.TIMEOUT_CYCLES(4), .CNT_W(10)) dut (
      .clk(clk), .rst(rst), .valid(valid), .ldst_ctrl(ldst_ctrl),
      .mem_write(mem_write), .mem_to_reg(mem_to_reg), .addr(addr),
      .store_data(store_data), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .stall(stall), .load_data(load_data),
      .load_valid(load_valid), .bus_err(bus_err), .misalign(misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && load_valid) begin
         if (sb.size() == 0) chk("lv_unexpected", 32'd1, 32'd0);
         else                chk("load_data", load_data, sb.pop_front());
      end
   end

   task automatic run_op(input string tag, input logic [2:0] ctrl, input logic mw, input logic mtr,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                         input int dly, input logic [31:0] exp_addr, input logic [3:0] exp_we,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_ld);
      int stall_cnt = 0;
      @(posedge clk); #1;
      valid = 1'b1; ldst_ctrl = ctrl; mem_write = mw; mem_to_reg = mtr;
      addr = a; store_data = sd;
      if (mtr) sb.push_back(exp_ld);
      @(negedge clk);
      chk({tag, "_req_start"}, {31'd0, dmem_req}, 32'd0);
      if (stall) stall_cnt++;
      for (int k = 0; k <= dly; k++) begin
         @(posedge clk); #1;
         dmem_ack = (k == dly); dmem_rdata = rd;
         @(negedge clk);
         if (k == 0) begin
            chk({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
            chk({tag, "_addr"}, dmem_addr, exp_addr);
            chk({tag, "_we"}, {28'd0, dmem_we}, {28'd0, exp_we});
            if (mw) chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
         end
         if (stall) stall_cnt++;
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0; valid = 1'b0;
      @(negedge clk);
      chk({tag, "_req_drop"}, {31'd0, dmem_req}, 32'd0);
      chk({tag, "_lv"}, {31'd0, load_valid}, {31'd0, mtr});
      chk({tag, "_stall_cycles"}, stall_cnt, 1 + dly);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      #12;
      chk("rst_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_outs", {dmem_we, 1'b0, stall, load_valid, bus_err, misalign}, 9'd0);
      chk("rst_ld", load_data, 32'd0);
      @(negedge clk); rst = 1'b0;

      run_op("lw",  3'd2, 1'b0, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 1, 32'h100, 4'b0000, 32'h0, 32'hDEADBEEF);
      run_op("lb",  3'd0, 1'b0, 1'b1, 32'h103, 32'h0, 32'h123456F0, 0, 32'h100, 4'b0000, 32'h0, 32'hFFFFFFF0);
      run_op("lbu", 3'd3, 1'b0, 1'b1, 32'h103, 32'h0, 32'h123456F0, 2, 32'h100, 4'b0000, 32'h0, 32'h000000F0);
      run_op("lh",  3'd1, 1'b0, 1'b1, 32'h102, 32'h0, 32'h00008001, 0, 32'h100, 4'b0000, 32'h0, 32'hFFFF8001);
      run_op("lhu", 3'd4, 1'b0, 1'b1, 32'h200, 32'h0, 32'h9ABC0000, 1, 32'h200, 4'b0000, 32'h0, 32'h00009ABC);
      run_op("sb",  3'd5, 1'b1, 1'b0, 32'h201, 32'hAB, 32'h0, 0, 32'h200, 4'b0100, 32'hABABABAB, 32'h0);
      run_op("sh",  3'd6, 1'b1, 1'b0, 32'h202, 32'h1234, 32'h0, 1, 32'h200, 4'b0011, 32'h12341234, 32'h0);
      run_op("sw",  3'd7, 1'b1, 1'b0, 32'h304, 32'hCAFEF00D, 32'h0, 0, 32'h304, 4'b1111, 32'hCAFEF00D, 32'h0);

      // encoding mismatch: store flag with a load encoding
      @(posedge clk); #1;
      valid = 1'b1; ldst_ctrl = 3'd2; mem_write = 1'b1; mem_to_reg = 1'b0; addr = 32'h40;
      @(negedge clk);
      chk("noop_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      chk("noop_req", {31'd0, dmem_req}, 32'd0);
      valid = 1'b0;

      // timeout with no ack
      @(posedge clk); #1;
      valid = 1'b1; ldst_ctrl = 3'd2; mem_write = 1'b0; mem_to_reg = 1'b1; addr = 32'h500;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (dmem_req) cnt++;
         if (!stall) break;
      end
      chk("to_access_cycles", cnt, 4);
      @(posedge clk); #1; valid = 1'b0;
      @(negedge clk);
      chk("to_bus_err", {31'd0, bus_err}, 32'd1);
      chk("to_req", {31'd0, dmem_req}, 32'd0);
      chk("to_stall", {31'd0, stall}, 32'd0);
      chk("to_ld_kept", load_data, 32'h00009ABC);
      @(negedge clk);
      chk("to_pulse", {31'd0, bus_err}, 32'd0);
      run_op("after_to", 3'd2, 1'b0, 1'b1, 32'h600, 32'h0, 32'h55AA33CC, 0, 32'h600, 4'b0000, 32'h0, 32'h55AA33CC);

      // reset in the middle of ACCESS
      @(posedge clk); #1;
      valid = 1'b1; ldst_ctrl = 3'd2; mem_write = 1'b0; mem_to_reg = 1'b1; addr = 32'h700;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_req", {31'd0, dmem_req}, 32'd1);
      #2; rst = 1'b1; valid = 1'b0; dmem_rdata = 32'h11111111;
      #1;
      chk("arst_req", {31'd0, dmem_req}, 32'd0);
      chk("arst_outs", {dmem_we, stall, load_valid, bus_err, misalign}, 8'd0);
      chk("arst_ld", load_data, 32'd0);
      @(negedge clk); @(negedge clk); rst = 1'b0;
      dmem_ack = 1'b1;
      repeat (3) @(negedge clk);
      dmem_ack = 1'b0;
      chk("arst_req_idle", {31'd0, dmem_req}, 32'd0);

`ifdef LSU_MISALIGN_TRAP_EN
      @(posedge clk); #1;
      valid = 1'b1; ldst_ctrl = 3'd2; mem_write = 1'b0; mem_to_reg = 1'b1; addr = 32'h102;
      @(negedge clk);
      chk("mis_stall", {31'd0, stall}, 32'd1);
      @(negedge clk);
      chk("mis_pulse", {31'd0, misalign}, 32'd1);
      chk("mis_req", {31'd0, dmem_req}, 32'd0);
      chk("mis_stall2", {31'd0, stall}, 32'd0);
      @(posedge clk); #1; valid = 1'b0;
      @(negedge clk);
      chk("mis_clear", {31'd0, misalign}, 32'd0);
      chk("mis_req2", {31'd0, dmem_req}, 32'd0);
`else
      run_op("lw_unal", 3'd2, 1'b0, 1'b1, 32'h102, 32'h0, 32'h0BADF00D, 0, 32'h100, 4'b0000, 32'h0, 32'h0BADF00D);
      chk("mis_tied", {31'd0, misalign}, 32'd0);
`endif

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
